// File: rtl/usr_serial_rx.sv
// Serial-to-parallel frame receiver: reassembles 4-bit words (LSB- or MSB-first) into a
// 2-entry valid/ready FIFO with sticky overflow. Define USR_RX_PARITY_EN for 5-bit frames with even parity.
module usr_serial_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_vld,
  input  logic       bit_in,
  input  logic       sof,
  input  logic       dir,
  output logic [3:0] out_data,
  output logic       out_perr,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       ovf,
  input  logic       clr_ovf,
  output logic       busy
);

`ifdef USR_RX_PARITY_EN
  localparam int unsigned EntryW = 5;
  localparam logic [2:0]  LastCnt = 3'd4;
`else
  localparam int unsigned EntryW = 4;
  localparam logic [2:0]  LastCnt = 3'd3;
`endif

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic [3:0]          data_q, data_d;
  logic [1:0]          pos;
  logic                push;
  logic [EntryW-1:0]   push_word;

  logic [EntryW-1:0]   mem_q [2];
  logic                wr_q, rd_q;
  logic [1:0]          fcnt_q;
  logic                ovf_q;
  logic                full, pop, wr_en, drop;
  logic [EntryW-1:0]   head;

  // Frame assembly
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    data_d    = data_q;
    push      = 1'b0;
    push_word = '0;
    pos       = dir_q ? (2'd3 - cnt_q[1:0]) : cnt_q[1:0];
    if (bit_vld) begin
      if (sof) begin
        // sof always restarts, discarding any partial frame
        data_d = '0;
        data_d[dir ? 2'd3 : 2'd0] = bit_in;
        dir_d   = dir;
        cnt_d   = 3'd1;
        state_d = StShift;
      end else if (state_q == StShift) begin
        if (cnt_q < 3'd4) begin
          data_d[pos] = bit_in;
        end
        if (cnt_q == LastCnt) begin
          push    = 1'b1;
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
    end
`ifdef USR_RX_PARITY_EN
    // Final bit is the parity bit, so data_d already holds the complete word
    push_word = {(^data_q) ^ bit_in, data_d};
`else
    push_word = data_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      dir_q   <= 1'b0;
      data_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  // Output FIFO
  assign full  = (fcnt_q == 2'd2);
  assign pop   = out_vld && out_rdy;
  // When full, wr_q == rd_q, so a write with a simultaneous pop replaces the departing head
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      fcnt_q   <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_word;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      if (wr_en && !pop) begin
        fcnt_q <= fcnt_q + 2'd1;
      end else if (!wr_en && pop) begin
        fcnt_q <= fcnt_q - 2'd1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign head     = mem_q[rd_q];
  assign out_vld  = (fcnt_q != 2'd0);
  assign out_data = out_vld ? head[3:0] : 4'd0;
`ifdef USR_RX_PARITY_EN
  assign out_perr = out_vld & head[4];
`else
  assign out_perr = 1'b0;
`endif
  assign ovf      = ovf_q;
  assign busy     = (state_q == StShift);

endmodule
